mem_access: RTL and testbench

//  MEM stage of the 5-stage pipeline; sits between ex_mem and mem_wb and consumes mem_wd/mem_wreg/mem_wdata.
//  Non-memory ops pass through in zero cycles. Loads and stores run a req/ack transaction on the data bus.
//  It raises stallreq until the transaction completes, then drives formatted load data or store write-back to mem_wb.

---
 rtl/mem_access.sv | 219 +++++++++++++++++++++
 tb/tb_mem_access.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM stage: zero-cycle pass-through for non-memory ops, req/ack data-bus transaction for loads/stores.
// Optional build macro MEM_ALIGN_CHECK_EN turns misaligned halfword/word accesses into aborted ops.
module mem_access #(
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  input  logic        wb_hold,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        bus_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic [1:0]  dbg_state
);
  // Bus handshake: dbus_req rises with a valid address/we/sel/wdata and holds them stable
  // until the cycle dbus_ack is seen (or the timeout fires); dbus_ack outside WAIT is ignored.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_e;

  localparam logic [8:0] TO_LIMIT = 9'(ACK_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        abort_q, abort_d;

  logic        is_load, is_store, is_mem, is_byte, is_half, is_word, is_signed;
  logic        misalign, ack_timeout;
  logic [3:0]  sel;
  logic [31:0] st_data, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    case (mem_op)
      4'd1:    begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      4'd2:    begin is_load = 1'b1; is_byte = 1'b1; end
      4'd3:    begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      4'd4:    begin is_load = 1'b1; is_half = 1'b1; end
      4'd5:    begin is_load = 1'b1; is_word = 1'b1; end
      4'd9:    begin is_store = 1'b1; is_byte = 1'b1; end
      4'd10:   begin is_store = 1'b1; is_half = 1'b1; end
      4'd11:   begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign ack_timeout = ({1'b0, cnt_q} + 9'd1) >= TO_LIMIT;

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    sel     = 4'b0000;
    st_data = 32'h0;
    if (is_byte) begin
      sel     = 4'b1000 >> mem_addr[1:0];
      st_data = {4{mem_sdata[7:0]}};
    end else if (is_half) begin
      sel     = mem_addr[1] ? 4'b0011 : 4'b1100;
      st_data = {2{mem_sdata[15:0]}};
    end else if (is_word) begin
      sel     = 4'b1111;
      st_data = mem_sdata;
    end
    if (!is_store) st_data = 32'h0;
  end

  always_comb begin
    case (mem_addr[1:0])
      2'd0:    ld_byte = rdata_q[31:24];
      2'd1:    ld_byte = rdata_q[23:16];
      2'd2:    ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    ld_data = rdata_q;
    if (is_byte)      ld_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
    else if (is_half) ld_data = {{16{is_signed & ld_half[15]}}, ld_half};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'h0;
      rdata_q   <= 32'h0;
      bus_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = 8'h0;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    abort_d   = abort_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (is_mem) begin
          if (misalign) begin
            state_d   = DONE;
            bus_err_d = 1'b1;
            abort_d   = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dbus_ack) begin
          state_d = DONE;
          rdata_d = dbus_rdata;
          abort_d = 1'b0;
        end else if (ack_timeout) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
          abort_d   = 1'b1;
        end else begin
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end
      end
      DONE: begin
        // Holding here keeps a stalled instruction from reissuing its access.
        if (!wb_hold) begin
          state_d = IDLE;
          abort_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = 32'h0;
    dbus_sel   = 4'b0000;
    dbus_wdata = 32'h0;
    stallreq   = 1'b0;
    wb_wd      = 5'd0;
    wb_wreg    = 1'b0;
    wb_wdata   = 32'h0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          wb_wd = mem_wd;
          if (is_mem) begin
            stallreq = 1'b1;
            if (!misalign) begin
              dbus_req   = 1'b1;
              dbus_we    = is_store;
              dbus_addr  = {mem_addr[31:2], 2'b00};
              dbus_sel   = sel;
              dbus_wdata = st_data;
            end
          end else begin
            wb_wreg  = mem_wreg;
            wb_wdata = mem_wdata;
          end
        end
        WAIT: begin
          wb_wd      = mem_wd;
          stallreq   = 1'b1;
          dbus_req   = 1'b1;
          dbus_we    = is_store;
          dbus_addr  = {mem_addr[31:2], 2'b00};
          dbus_sel   = sel;
          dbus_wdata = st_data;
        end
        DONE: begin
          wb_wd = mem_wd;
          if (is_load && !abort_q) begin
            wb_wreg  = mem_wreg;
            wb_wdata = ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed transactions, a per-cycle expectation queue built from the
// access rules, and literal spot checks on the headline scenarios.
`timescale 1ns/1ps
module tb_mem_access;
  localparam int ACK_TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        wb_hold;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        bus_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_ack;
  logic [1:0]  dbg_state;

  mem_access #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
    .wb_hold(wb_hold),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .stallreq(stallreq), .bus_err(bus_err),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stallreq;
    logic        bus_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
  endtask

  // ---------------- reference model of the access rules ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd9:  return 1;
      4'd3, 4'd4, 4'd10: return 2;
      4'd5, 4'd11:       return 4;
      default:           return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [3:0] op);
    return (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
  endfunction

  function automatic bit op_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit misaligned(input logic [3:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    return (op_size(op) > 1) && ((addr % op_size(op)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lane_off(input logic [3:0] op, input logic [31:0] addr);
    int sz;
    sz = op_size(op);
    return (int'(addr % 4) / sz) * sz;
  endfunction

  function automatic logic [3:0] sel_model(input logic [3:0] op, input logic [31:0] addr);
    logic [3:0] s;
    int o, sz;
    s = 4'b0000;
    sz = op_size(op);
    o = lane_off(op, addr);
    for (int i = 0; i < 4; i++)
      if (i >= o && i < o + sz) s[3 - i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] st_model(input logic [3:0] op, input logic [31:0] sd);
    case (op)
      4'd9:    return {24'h0, sd[7:0]} * 32'h0101_0101;
      4'd10:   return {16'h0, sd[15:0]} * 32'h0001_0001;
      4'd11:   return sd;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ld_model(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
    longint mask, val;
    int sz, o;
    sz = op_size(op);
    o = lane_off(op, addr);
    mask = (64'd1 << (8 * sz)) - 1;
    val = (longint'(rd) >> (8 * (4 - o - sz))) & mask;
    if ((op == 4'd1 || op == 4'd3) && val[8 * sz - 1]) val = val | ~mask;
    return val[31:0];
  endfunction

  function automatic exp_t pass_exp(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    exp_t e;
    e = '0;
    e.wb_wd = wd;
    e.wb_wreg = wreg;
    e.wb_wdata = wdata;
    return e;
  endfunction

  function automatic exp_t issue_exp(input logic [3:0] op, input logic [4:0] wd,
                                     input logic [31:0] addr, input logic [31:0] sd);
    exp_t e;
    e = '0;
    e.stallreq = 1'b1;
    e.wb_wd = wd;
    if (!misaligned(op, addr)) begin
      e.dbus_req   = 1'b1;
      e.dbus_we    = op_is_store(op);
      e.dbus_addr  = addr & 32'hFFFF_FFFC;
      e.dbus_sel   = sel_model(op, addr);
      e.dbus_wdata = st_model(op, sd);
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] sd);
    mem_op = op; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
    mem_addr = addr; mem_sdata = sd;
  endtask

  task automatic pass_cycle(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                            input logic [31:0] wdata);
    next_cycle();
    set_in(op, wd, wreg, wdata, 32'h0000_0F00, 32'h0);
    wb_hold = 1'b0; dbus_ack = 1'b0;
    exp_q.push_back(pass_exp(wd, wreg, wdata));
  endtask

  // ack_at: WAIT cycle (1-based) carrying dbus_ack; 0 = never acknowledged
  task automatic run_txn(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rd,
                         input int ack_at, input int hold_n);
    exp_t e, d;
    bit err;
    next_cycle();
    set_in(op, wd, wreg, 32'h7777_0000 | 32'(wd), addr, sd);
    wb_hold = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h5A5A_5A5A;
    e = issue_exp(op, wd, addr, sd);
    exp_q.push_back(e);
    err = misaligned(op, addr);
    if (!err) begin
      for (int w = 1; w <= ACK_TO; w++) begin
        next_cycle();
        dbus_ack = (w == ack_at);
        dbus_rdata = (w == ack_at) ? rd : 32'h5A5A_5A5A;
        exp_q.push_back(e);
        if (w == ack_at) break;
        if (w == ACK_TO) err = 1'b1;
      end
    end
    for (int k = 0; k <= hold_n; k++) begin
      next_cycle();
      dbus_ack = (k == 0 && err) || (k == 1);
      dbus_rdata = 32'hA5A5_A5A5;
      wb_hold = (k < hold_n);
      d = '0;
      d.wb_wd = wd;
      d.bus_err = err && (k == 0);
      d.wb_wreg = op_is_load(op) && !err && wreg;
      d.wb_wdata = (op_is_load(op) && !err) ? ld_model(op, addr, rd) : 32'h0;
      exp_q.push_back(d);
    end
    pass_cycle(4'd0, 5'd0, 1'b0, 32'hC0DE_0000);
  endtask

  // ---------------- compare process and event statistics ----------------
  int stall_cnt = 0, req_cnt = 0, req_rise = 0, err_cnt = 0, hold_cnt = 0;
  logic prev_req = 1'b0, prev_stall = 1'b0;
  logic [3:0]  iss_sel;
  logic [31:0] iss_wdata, done_wdata;
  logic        iss_we, done_wreg, done_err;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("stallreq",   32'(stallreq),   32'(ce.stallreq));
      chk("bus_err",    32'(bus_err),    32'(ce.bus_err));
      chk("dbus_req",   32'(dbus_req),   32'(ce.dbus_req));
      chk("dbus_we",    32'(dbus_we),    32'(ce.dbus_we));
      chk("dbus_addr",  dbus_addr,       ce.dbus_addr);
      chk("dbus_sel",   32'(dbus_sel),   32'(ce.dbus_sel));
      chk("dbus_wdata", dbus_wdata,      ce.dbus_wdata);
      chk("wb_wd",      32'(wb_wd),      32'(ce.wb_wd));
      chk("wb_wreg",    32'(wb_wreg),    32'(ce.wb_wreg));
      chk("wb_wdata",   wb_wdata,        ce.wb_wdata);
    end
    if (rst) begin
      if (stallreq) stall_cnt++;
      if (dbus_req) req_cnt++;
      if (bus_err) err_cnt++;
      if (wb_wdata == 32'h1234_5678) hold_cnt++;
      if (dbus_req && !prev_req) begin
        req_rise++;
        iss_sel = dbus_sel; iss_wdata = dbus_wdata; iss_we = dbus_we;
      end
      if (prev_stall && !stallreq) begin
        done_wdata = wb_wdata; done_wreg = wb_wreg; done_err = bus_err;
      end
      prev_req = dbus_req;
      prev_stall = stallreq;
    end
  end

  int s0, r0, rr0, e0, h0;

  task automatic snap();
    s0 = stall_cnt; r0 = req_cnt; rr0 = req_rise; e0 = err_cnt; h0 = hold_cnt;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    set_in(4'd5, 5'd7, 1'b1, 32'h1111_1111, 32'h0000_0104, 32'h2222_2222);
    wb_hold = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    #12;
    chk("rst dbus_req",  32'(dbus_req), 32'h0);
    chk("rst stallreq",  32'(stallreq), 32'h0);
    chk("rst wb_wreg",   32'(wb_wreg),  32'h0);
    chk("rst wb_wdata",  wb_wdata,      32'h0);
    chk("rst bus_err",   32'(bus_err),  32'h0);
    chk("rst state",     32'(dbg_state), 32'h0);
    set_in(4'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1 rst = 1'b1;

    // pass-through, including an undefined op code and a stray ack in IDLE
    pass_cycle(4'd0, 5'd3, 1'b1, 32'hDEAD_BEEF);
    dbus_ack = 1'b1;
    #3;
    chk("pass wb_wdata", wb_wdata, 32'hDEAD_BEEF);
    chk("pass wb_wd",    32'(wb_wd), 32'd3);
    chk("pass dbus_req", 32'(dbus_req), 32'h0);
    pass_cycle(4'd7, 5'd9, 1'b1, 32'h0BAD_F00D);
    pass_cycle(4'd0, 5'd1, 1'b0, 32'h1234_0000);

    // LB sign extension, minimum latency
    snap();
    run_txn(4'd1, 5'd4, 1'b1, 32'h0000_0100, 32'h0, 32'h8012_3456, 1, 0);
    settle();
    chk("lb wdata", done_wdata, 32'hFFFF_FF80);
    chk("lb stall cycles", 32'(stall_cnt - s0), 32'd2);

    // SH to the low halfword
    run_txn(4'd10, 5'd5, 1'b1, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 2, 0);
    settle();
    chk("sh sel",   32'(iss_sel), 32'h3);
    chk("sh wdata", iss_wdata, 32'hABCD_ABCD);
    chk("sh we",    32'(iss_we), 32'h1);
    chk("sh wreg",  32'(done_wreg), 32'h0);

    // timeout with a late ack in DONE
    snap();
    run_txn(4'd5, 5'd6, 1'b1, 32'h0000_0010, 32'h0, 32'hFFFF_0000, 0, 0);
    settle();
    chk("to req cycles", 32'(req_cnt - r0), 32'd5);
    chk("to err pulses", 32'(err_cnt - e0), 32'd1);
    chk("to wreg",       32'(done_wreg), 32'h0);
    chk("to bus_err",    32'(done_err), 32'h1);

    // LW held in DONE for 3 cycles
    snap();
    run_txn(4'd5, 5'd8, 1'b1, 32'h0000_0200, 32'h0, 32'h1234_5678, 1, 3);
    settle();
    chk("hold req count", 32'(req_rise - rr0), 32'd1);
    chk("hold wdata cycles", 32'(hold_cnt - h0), 32'd4);
    chk("hold wdata", done_wdata, 32'h1234_5678);

    // remaining lane / extension / latency variants
    run_txn(4'd2,  5'd10, 1'b1, 32'h0000_0103, 32'h0, 32'h1122_3344, 1, 0);
    settle();
    chk("lbu wdata", done_wdata, 32'h0000_0044);
    run_txn(4'd3,  5'd11, 1'b1, 32'h0000_0100, 32'h0, 32'h8001_7FFF, 2, 1);
    run_txn(4'd4,  5'd12, 1'b1, 32'h0000_0102, 32'h0, 32'h1234_F00D, 1, 0);
    settle();
    chk("lhu wdata", done_wdata, 32'h0000_F00D);
    run_txn(4'd9,  5'd13, 1'b1, 32'h0000_0101, 32'h0000_00EE, 32'h0, 1, 0);
    run_txn(4'd11, 5'd14, 1'b1, 32'h0000_0104, 32'hCAFE_BABE, 32'h0, ACK_TO, 0);
    run_txn(4'd5,  5'd15, 1'b0, 32'h0000_0108, 32'h0, 32'h0F0F_0F0F, 3, 0);
    run_txn(4'd3,  5'd16, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_7FFE, 1, 0);

    // misaligned word access
    snap();
    run_txn(4'd5, 5'd17, 1'b1, 32'h0000_0101, 32'h0, 32'h8765_4321, 1, 0);
    settle();
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis req cycles", 32'(req_cnt - r0), 32'd0);
    chk("mis err pulses", 32'(err_cnt - e0), 32'd1);
    chk("mis stall cycles", 32'(stall_cnt - s0), 32'd1);
`else
    chk("mis req cycles", 32'(req_cnt - r0), 32'd2);
    chk("mis err pulses", 32'(err_cnt - e0), 32'd0);
    chk("mis wdata", done_wdata, 32'h8765_4321);
`endif

    // reset in the middle of WAIT
    next_cycle();
    set_in(4'd5, 5'd18, 1'b1, 32'h0, 32'h0000_0300, 32'h0);
    dbus_ack = 1'b0;
    exp_q.push_back(issue_exp(4'd5, 5'd18, 32'h0000_0300, 32'h0));
    next_cycle();
    exp_q.push_back(issue_exp(4'd5, 5'd18, 32'h0000_0300, 32'h0));
    settle();
    rst = 1'b0;
    #1;
    chk("midrst dbus_req", 32'(dbus_req), 32'h0);
    chk("midrst stallreq", 32'(stallreq), 32'h0);
    chk("midrst state",    32'(dbg_state), 32'h0);
    @(posedge clk);
    #1;
    set_in(4'd0, 5'd9, 1'b1, 32'hABCD_0123, 32'h0, 32'h0);
    #1;
    chk("midrst wb_wdata", wb_wdata, 32'h0);
    rst = 1'b1;
    #1;
    chk("post rst state",  32'(dbg_state), 32'h0);
    chk("post rst wdata",  wb_wdata, 32'hABCD_0123);
    pass_cycle(4'd0, 5'd2, 1'b1, 32'h5555_AAAA);
    run_txn(4'd1, 5'd19, 1'b1, 32'h0000_0302, 32'h0, 32'h0000_7F00, 1, 0);
    settle();
    chk("post rst lb", done_wdata, 32'h0000_007F);

    settle();
    chk("queue drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
